// File: rtl/dino_jump_ctrl_if.sv
// rtl/dino_jump_ctrl_if.sv - frame tick, button, halt and position/status signals of the dino jump controller
interface dino_jump_ctrl_if #(
  parameter int Y_W = 7
);
  logic           frame_tick;
  logic           jump_btn;
  logic           duck_btn;
  logic           halt;
  logic [Y_W-1:0] dino_y;
  logic           airborne;
  logic           ducking;
  logic           land_pulse;

  modport master (
    output frame_tick, jump_btn, duck_btn, halt,
    input  dino_y, airborne, ducking, land_pulse
  );

  modport slave (
    input  frame_tick, jump_btn, duck_btn, halt,
    output dino_y, airborne, ducking, land_pulse
  );
endinterface

// File: rtl/dino_jump_ctrl.sv
// rtl/dino_jump_ctrl.sv - per-frame dino jump physics (launch, gravity, apex, landing, halt)
// Optional macro FAST_FALL_EN: duck_btn doubles gravity while airborne.
module dino_jump_ctrl #(
  parameter int Y_W      = 7,
  parameter int VEL_W    = 6,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_Y    = 100
) (
  input logic             clk,
  input logic             reset_n,
  dino_jump_ctrl_if.slave bus
);

  // Two guard bits so y + vel can never wrap, whatever the parameters.
  localparam int N_W = ((Y_W > VEL_W) ? Y_W : VEL_W) + 2;

  localparam logic signed [N_W-1:0] GRAV_S    = N_W'(GRAVITY);
  localparam logic signed [N_W-1:0] VEL_MIN_S = N_W'(-(2 ** (VEL_W - 1)));
  localparam logic signed [N_W-1:0] MAX_Y_S   = N_W'(MAX_Y);

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [Y_W-1:0]            r_y, w_y_nxt;
  logic signed [VEL_W-1:0]   r_vel, w_vel_nxt;
  logic                      r_jump_pend, w_jump_pend_nxt;
  logic                      r_btn_prev;
  logic                      r_land, w_land_nxt;
  logic                      r_ducking;

  logic                      w_press;
  logic signed [N_W-1:0]     w_y_ext, w_vel_ext, w_dec, w_sum, w_vel_dec;
  logic [Y_W-1:0]            w_y_new;
  logic signed [VEL_W-1:0]   w_vel_new;
  state_t                    w_resume;

  assign w_press   = bus.jump_btn & ~r_btn_prev;
  assign w_y_ext   = {{(N_W-Y_W){1'b0}}, r_y};
  assign w_vel_ext = {{(N_W-VEL_W){r_vel[VEL_W-1]}}, r_vel};

`ifdef FAST_FALL_EN
  assign w_dec = bus.duck_btn ? (GRAV_S + GRAV_S) : GRAV_S;
`else
  assign w_dec = GRAV_S;
`endif

  assign w_sum     = w_y_ext + w_vel_ext;
  assign w_vel_dec = w_vel_ext - w_dec;
  assign w_vel_new = (w_vel_dec < VEL_MIN_S) ? VEL_MIN_S[VEL_W-1:0] : w_vel_dec[VEL_W-1:0];
  assign w_y_new   = (w_sum > MAX_Y_S) ? MAX_Y_S[Y_W-1:0] : w_sum[Y_W-1:0];

  // State to re-enter when halt drops, rebuilt from the frozen motion.
  assign w_resume = (r_y == '0) ? GROUNDED : ((r_vel > 0) ? RISING : FALLING);

  always_comb begin
    w_state_nxt     = r_state;
    w_y_nxt         = r_y;
    w_vel_nxt       = r_vel;
    w_jump_pend_nxt = r_jump_pend;
    w_land_nxt      = 1'b0;
    if (bus.halt) begin
      w_state_nxt     = HALTED;
      w_jump_pend_nxt = 1'b0;
    end else begin
      case (r_state)
        GROUNDED: begin
          if (bus.frame_tick && (r_jump_pend || w_press)) begin
            w_y_nxt         = Y_W'(JUMP_VEL);
            w_vel_nxt       = VEL_W'(JUMP_VEL - GRAVITY);
            w_jump_pend_nxt = 1'b0;
            w_state_nxt     = RISING;
          end else if (w_press) begin
            w_jump_pend_nxt = 1'b1;
          end
        end
        RISING, FALLING: begin
          if (bus.frame_tick) begin
            if (w_sum <= 0) begin
              w_y_nxt     = '0;
              w_vel_nxt   = '0;
              w_land_nxt  = 1'b1;
              w_state_nxt = GROUNDED;
            end else begin
              w_y_nxt     = w_y_new;
              w_vel_nxt   = w_vel_new;
              w_state_nxt = (w_vel_new > 0) ? RISING : FALLING;
            end
          end
        end
        HALTED:  w_state_nxt = w_resume;
        default: w_state_nxt = GROUNDED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= GROUNDED;
      r_y         <= '0;
      r_vel       <= '0;
      r_jump_pend <= 1'b0;
      r_btn_prev  <= 1'b1;
      r_land      <= 1'b0;
      r_ducking   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_y         <= w_y_nxt;
      r_vel       <= w_vel_nxt;
      r_jump_pend <= w_jump_pend_nxt;
      r_btn_prev  <= bus.jump_btn;
      r_land      <= w_land_nxt;
      r_ducking   <= (w_state_nxt == GROUNDED) & bus.duck_btn;
    end
  end

  assign bus.dino_y     = r_y;
  assign bus.airborne   = (r_state == RISING) || (r_state == FALLING);
  assign bus.ducking    = r_ducking;
  assign bus.land_pulse = r_land;

endmodule
